// File: rtl/ls160_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ls160_chain_ctrl_if
// Brief    : Control/status and LS160 chain bus for ls160_chain_ctrl.
//            WRAP exists only when LS160_CHAIN_WRAP_EN is defined.
// Revision : 1.0
// ============================================================================
interface ls160_chain_ctrl_if #(
    parameter int DIGITS = 2,
    parameter int LW     = 16
);
    logic                  START;
    logic                  ABORT;
    logic                  PAUSE;
    logic                  AUTO;
    logic [4*DIGITS-1:0]   PRESET;
    logic [4*DIGITS-1:0]   TARGET;
    logic [4*DIGITS-1:0]   CNT_Q;
    logic                  CNT_RCO;
    logic [4*DIGITS-1:0]   CNT_D;
    logic                  CNT_LOAD;
    logic                  CNT_ENP;
    logic                  CNT_ENT;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERR;
    logic [LW-1:0]         RUN_LEN;
`ifdef LS160_CHAIN_WRAP_EN
    logic                  WRAP;
`endif

    // master = control logic plus the counter chain; slave = the controller
    modport master (
`ifdef LS160_CHAIN_WRAP_EN
        input  WRAP,
`endif
        output START, ABORT, PAUSE, AUTO, PRESET, TARGET, CNT_Q, CNT_RCO,
        input  CNT_D, CNT_LOAD, CNT_ENP, CNT_ENT, BUSY, DONE, ERR, RUN_LEN
    );

    modport slave (
`ifdef LS160_CHAIN_WRAP_EN
        output WRAP,
`endif
        input  START, ABORT, PAUSE, AUTO, PRESET, TARGET, CNT_Q, CNT_RCO,
        output CNT_D, CNT_LOAD, CNT_ENP, CNT_ENT, BUSY, DONE, ERR, RUN_LEN
    );
endinterface
`default_nettype wire

// File: rtl/ls160_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ls160_chain_ctrl
// Brief    : Load/count/stop sequencer for a cascade of LS160 BCD counters.
//            Optional wrap flag enabled by macro LS160_CHAIN_WRAP_EN.
// Revision : 1.0
// ============================================================================
module ls160_chain_ctrl #(
    parameter int DIGITS = 2,
    parameter int LW     = 16
) (
    input  wire logic        CLK,
    input  wire logic        CLR,
    ls160_chain_ctrl_if.slave bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [LW-1:0] C_RUN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic [W-1:0]    load_val_q, load_val_d;
    logic [W-1:0]    target_q,   target_d;
    logic            auto_q,     auto_d;
    logic            err_q,      err_d;
    logic [LW-1:0]   run_cnt_q,  run_cnt_d;
    logic [LW-1:0]   run_len_q,  run_len_d;
    logic            wrap_q,     wrap_d;

    logic            w_digits_ok;
    logic            w_match;
    logic            w_en;

    always_comb begin
        w_digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.PRESET[4*i +: 4] > 4'd9 || bus.TARGET[4*i +: 4] > 4'd9)
                w_digits_ok = 1'b0;
        end
    end

    // Enables are combinational so the chain stops on the very edge it reaches TARGET
    assign w_match = (bus.CNT_Q == target_q);
    assign w_en    = (state_q == S_RUN) && !w_match && !bus.PAUSE;

    always_comb begin
        state_d    = state_q;
        load_val_d = load_val_q;
        target_d   = target_q;
        auto_d     = auto_q;
        err_d      = err_q;
        run_cnt_d  = run_cnt_q;
        run_len_d  = run_len_q;
        wrap_d     = wrap_q;

        if (bus.ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        if (w_digits_ok) begin
                            load_val_d = bus.PRESET;
                            target_d   = bus.TARGET;
                            auto_d     = bus.AUTO;
                            err_d      = 1'b0;
                            wrap_d     = 1'b0;
                            state_d    = S_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    if (w_en && run_cnt_q != C_RUN_MAX)
                        run_cnt_d = run_cnt_q + LW'(1);
                    if (w_en && bus.CNT_RCO)
                        wrap_d = 1'b1;
                    if (w_match) begin
                        run_len_d = run_cnt_q;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (auto_q) begin
                        wrap_d  = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            load_val_q <= '0;
            target_q   <= '0;
            auto_q     <= 1'b0;
            err_q      <= 1'b0;
            run_cnt_q  <= '0;
            run_len_q  <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_val_q <= load_val_d;
            target_q   <= target_d;
            auto_q     <= auto_d;
            err_q      <= err_d;
            run_cnt_q  <= run_cnt_d;
            run_len_q  <= run_len_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.CNT_D    = load_val_q;
    assign bus.CNT_LOAD = (state_q != S_LOAD);
    assign bus.CNT_ENP  = w_en;
    assign bus.CNT_ENT  = w_en;
    assign bus.BUSY     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign bus.DONE     = (state_q == S_DONE);
    assign bus.ERR      = err_q;
    assign bus.RUN_LEN  = run_len_q;

`ifdef LS160_CHAIN_WRAP_EN
    assign bus.WRAP = wrap_q;
`else
    // Wrap tracking has no observer in this build; RCO is deliberately ignored
    logic w_unused_rco;
    logic w_unused_wrap;
    assign w_unused_rco  = bus.CNT_RCO;
    assign w_unused_wrap = wrap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ls160_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls160_chain_ctrl
// Brief    : Directed bench for ls160_chain_ctrl with a 2-digit LS160 chain model.
//            Checks WRAP when LS160_CHAIN_WRAP_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_ls160_chain_ctrl;
    localparam int D = 2;
    localparam int L = 16;
    localparam int W = 4 * D;
    localparam logic [W-1:0] C_NINES = {D{4'h9}};

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    ls160_chain_ctrl_if #(.DIGITS(D), .LW(L)) bus ();

    ls160_chain_ctrl #(.DIGITS(D), .LW(L)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural LS160 cascade: synchronous load, BCD count when ENP & ENT
    logic [W-1:0] chain_q = '0;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!bus.CNT_LOAD)                    chain_q <= bus.CNT_D;
        else if (bus.CNT_ENP && bus.CNT_ENT)  chain_q <= bcd_inc(chain_q);
    end

    assign bus.CNT_Q   = chain_q;
    assign bus.CNT_RCO = bus.CNT_ENT && (chain_q == C_NINES);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_pulse(input logic [W-1:0] p, input logic [W-1:0] t, input logic a);
        bus.PRESET = p;
        bus.TARGET = t;
        bus.AUTO   = a;
        bus.START  = 1'b1;
        @(negedge clk);
        bus.START  = 1'b0;
    endtask

    // Returns the number of edges after the START edge until DONE is seen
    task automatic wait_done(output int k);
        k = 0;
        while (!bus.DONE && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bus.DONE) check("done_timeout", 32'(k), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] preset;
        logic [W-1:0] target;
        int           exp_len;
        int           exp_lat;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        int pcnt;
        int dones;
        logic paused;

        vecs[0] = '{8'h00, 8'h02,  2,   4, 1'b0};
        vecs[1] = '{8'h07, 8'h12,  5,   7, 1'b0};
        vecs[2] = '{8'h95, 8'h03,  8,  10, 1'b1};
        vecs[3] = '{8'h44, 8'h44,  0,   2, 1'b0};
        vecs[4] = '{8'h09, 8'h10,  1,   3, 1'b0};
        vecs[5] = '{8'h50, 8'h49, 99, 101, 1'b1};

        bus.START = 1'b0; bus.ABORT = 1'b0; bus.PAUSE = 1'b0; bus.AUTO = 1'b0;
        bus.PRESET = '0;  bus.TARGET = '0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;

        check("rst_load",  32'(bus.CNT_LOAD), 32'd1);
        check("rst_enp",   32'(bus.CNT_ENP),  32'd0);
        check("rst_ent",   32'(bus.CNT_ENT),  32'd0);
        check("rst_d",     32'(bus.CNT_D),    32'd0);
        check("rst_busy",  32'(bus.BUSY),     32'd0);
        check("rst_done",  32'(bus.DONE),     32'd0);
        check("rst_err",   32'(bus.ERR),      32'd0);
        check("rst_len",   32'(bus.RUN_LEN),  32'd0);
`ifdef LS160_CHAIN_WRAP_EN
        check("rst_wrap",  32'(bus.WRAP),     32'd0);
`endif

        // Non-BCD preset digit is rejected
        start_pulse(8'h1A, 8'h05, 1'b0);
        check("err_set",   32'(bus.ERR),      32'd1);
        check("err_busy",  32'(bus.BUSY),     32'd0);
        check("err_load",  32'(bus.CNT_LOAD), 32'd1);
        @(negedge clk);
        check("err_load2", 32'(bus.CNT_LOAD), 32'd1);
        check("err_d",     32'(bus.CNT_D),    32'd0);

        for (int v = 0; v < 6; v++) begin
            start_pulse(vecs[v].preset, vecs[v].target, 1'b0);
            check("vec_loadlow", 32'(bus.CNT_LOAD), 32'd0);
            check("vec_busy",    32'(bus.BUSY),     32'd1);
            wait_done(k);
            check("vec_latency", 32'(k),            32'(vecs[v].exp_lat));
            check("vec_runlen",  32'(bus.RUN_LEN),  32'(vecs[v].exp_len));
            check("vec_q",       32'(bus.CNT_Q),    32'(vecs[v].target));
            check("vec_err",     32'(bus.ERR),      32'd0);
            check("vec_dbusy",   32'(bus.BUSY),     32'd0);
`ifdef LS160_CHAIN_WRAP_EN
            check("vec_wrap",    32'(bus.WRAP),     32'(vecs[v].exp_wrap));
`endif
            @(negedge clk);
            check("vec_idle",    32'(bus.DONE | bus.BUSY), 32'd0);
            check("vec_hold",    32'(bus.CNT_Q),    32'(vecs[v].target));
        end

        // PAUSE for 3 cycles at 02; a bad START mid-run must be ignored
        start_pulse(8'h00, 8'h05, 1'b0);
        k = 0; pcnt = 0; paused = 1'b0;
        while (!bus.DONE && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) begin bus.PRESET = 8'h1A; bus.START = 1'b1; end
            if (k == 2) bus.START = 1'b0;
            if (pcnt > 0) begin
                check("pause_hold", 32'(bus.CNT_Q),   32'h02);
                check("pause_en",   32'(bus.CNT_ENP), 32'd0);
                pcnt--;
                if (pcnt == 0) bus.PAUSE = 1'b0;
            end else if (!paused && bus.CNT_Q == 8'h02) begin
                bus.PAUSE = 1'b1;
                paused    = 1'b1;
                pcnt      = 3;
            end
        end
        check("pause_latency", 32'(k),           32'd10);
        check("pause_runlen",  32'(bus.RUN_LEN), 32'd5);
        check("pause_err",     32'(bus.ERR),     32'd0);
        @(negedge clk);

        // AUTO reload then ABORT during the repeat
        start_pulse(8'h10, 8'h12, 1'b1);
        wait_done(k);
        check("auto_latency", 32'(k),            32'd4);
        check("auto_runlen",  32'(bus.RUN_LEN),  32'd2);
        @(negedge clk);
        check("auto_reload",  32'(bus.CNT_LOAD), 32'd0);
        check("auto_busy",    32'(bus.BUSY),     32'd1);
        @(negedge clk);
        check("auto_q",       32'(bus.CNT_Q),    32'h10);
        k = 0;
        while (bus.CNT_Q != 8'h11 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach", 32'(bus.CNT_Q), 32'h11);
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        check("abort_en",   32'(bus.CNT_ENP | bus.CNT_ENT), 32'd0);
        check("abort_load", 32'(bus.CNT_LOAD), 32'd1);
        check("abort_busy", 32'(bus.BUSY),     32'd0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.DONE) dones++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(dones),       32'd0);
        check("abort_runlen", 32'(bus.RUN_LEN), 32'd2);

        // CLR in the middle of a long run
        start_pulse(8'h00, 8'h50, 1'b0);
        repeat (5) @(negedge clk);
        check("clr_running", 32'(bus.CNT_ENP), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_load", 32'(bus.CNT_LOAD), 32'd1);
        check("clr_en",   32'(bus.CNT_ENP | bus.CNT_ENT), 32'd0);
        check("clr_d",    32'(bus.CNT_D),    32'd0);
        check("clr_busy", 32'(bus.BUSY),     32'd0);
        check("clr_done", 32'(bus.DONE),     32'd0);
        check("clr_len",  32'(bus.RUN_LEN),  32'd0);
        check("clr_err",  32'(bus.ERR),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
